// File: rtl/mdu.sv
// mdu: iterative multiply/divide unit that owns the HI/LO registers.
// MULT/MULTU use a shift-add multiplier and DIV/DIVU use a restoring divider.
// Both retire one bit per cycle over WIDTH iterations, followed by one
// sign-fix cycle. MTHI/MTLO writes are accepted only while the unit is idle.
module mdu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             flush,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             state;
   state_t             state_next;

   logic [CW-1:0]      cnt;
   logic               is_div;
   logic               neg_res;
   logic               neg_rem;
   logic               div_zero;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quo;

   logic               accept;
   logic               b_zero;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_trial;
   logic [WIDTH-1:0]   div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign busy   = (state != IDLE);
   assign accept = (state == IDLE) && start && !flush;

   // Operand magnitudes. A signed divide by zero keeps A raw so HI returns it untouched.
   always_comb begin
      b_zero = (B == '0);
      a_mag  = (op[0] && A[WIDTH-1] && !(op[1] && b_zero)) ? -A : A;
      b_mag  = (op[0] && B[WIDTH-1]) ? -B : B;
   end

   // One multiply step, one restoring-divide step, and the final sign correction.
   always_comb begin
      mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
      div_trial = {rem, quo[WIDTH-1]};
      div_ge    = (div_trial >= {1'b0, mcand});
      div_diff  = div_trial[WIDTH-1:0] - mcand;
      prod_fix  = neg_res ? -prod : prod;
      quo_fix   = (neg_res && !div_zero) ? -quo : quo;
      rem_fix   = (neg_rem && !div_zero) ? -rem : rem;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. A flush aborts RUN/FIX straight back to IDLE.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (flush) begin
               state_next = IDLE;
            end else if (cnt == LAST) begin
               state_next = FIX;
            end
         end
         FIX: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Iteration datapath: latch operands on accept, then retire one bit per RUN cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         is_div   <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         mcand    <= '0;
         prod     <= '0;
         rem      <= '0;
         quo      <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  is_div   <= op[1];
                  neg_res  <= op[0] & (A[WIDTH-1] ^ B[WIDTH-1]);
                  neg_rem  <= op[0] & A[WIDTH-1];
                  div_zero <= op[1] & b_zero;
                  mcand    <= op[1] ? b_mag : a_mag;
                  prod     <= {{WIDTH{1'b0}}, b_mag};
                  quo      <= a_mag;
                  rem      <= '0;
                  cnt      <= '0;
               end
            end
            RUN: begin
               cnt <= cnt + 1'b1;
               if (is_div) begin
                  if (div_ge) begin
                     rem <= div_diff;
                     quo <= {quo[WIDTH-2:0], 1'b1};
                  end else begin
                     rem <= div_trial[WIDTH-1:0];
                     quo <= {quo[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  prod <= {mul_sum, prod[WIDTH-1:1]};
               end
            end
            default: begin
            end
         endcase
      end
   end

   // HI/LO: MTHI/MTLO while idle, result commit with a done pulse from FIX.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi   <= '0;
         lo   <= '0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (wr_hi) begin
               hi <= wdata;
            end
            if (wr_lo) begin
               lo <= wdata;
            end
         end else if (state == FIX && !flush) begin
            done <= 1'b1;
            if (is_div) begin
               hi <= rem_fix;
               lo <= quo_fix;
            end else begin
               hi <= prod_fix[2*WIDTH-1:WIDTH];
               lo <= prod_fix[WIDTH-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: scoreboard bench for the multiply/divide unit.
// Stimulus pushes the hand-computed HI/LO results into a queue.
// A monitor pops and checks an entry on every done pulse.
module tb_mdu;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        flush;
   logic        wr_hi;
   logic        wr_lo;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   typedef struct {
      logic [31:0] e_hi;
      logic [31:0] e_lo;
   } exp_t;

   typedef struct packed {
      logic [1:0]  v_op;
      logic [31:0] v_a;
      logic [31:0] v_b;
      logic [31:0] v_hi;
      logic [31:0] v_lo;
   } vec_t;

   exp_t   exp_q[$];
   exp_t   mon_e;
   vec_t   vecs[8];
   int     total = 0;
   int     bad = 0;
   int     cyc = 0;
   int     start_cyc = 0;
   logic   prev_done = 1'b0;

   mdu #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .A     (A),
      .B     (B),
      .flush (flush),
      .wr_hi (wr_hi),
      .wr_lo (wr_lo),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Cycle counter for latency measurement.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
      end
   endtask

   // Called on a falling edge: issue one operation and optionally queue its result.
   task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic push, input logic [31:0] eh, input logic [31:0] el);
      op    = o;
      A     = a;
      B     = b;
      start = 1'b1;
      if (push) begin
         exp_q.push_back('{e_hi: eh, e_lo: el});
      end
      @(negedge clk);
      start     = 1'b0;
      start_cyc = cyc;
      checkOutput("busy_after_accept", {31'b0, busy}, 32'd1);
   endtask

   // Bounded wait for done; it must arrive 33 edges after the accepting edge.
   task automatic waitDone();
      while (!done && (cyc - start_cyc) < 60) begin
         @(negedge clk);
      end
      checkOutput("latency", 32'(cyc - start_cyc), 32'd33);
   endtask

   // Monitor: on each done pulse pop the scoreboard and compare HI/LO.
   always @(negedge clk) begin
      if (!rst && done) begin
         checkOutput("done_width", {31'b0, prev_done}, 32'd0);
         checkOutput("busy_in_done", {31'b0, busy}, 32'd0);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_done: got done=1 (hi=%h lo=%h), required no done", hi, lo);
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput("result_hi", hi, mon_e.e_hi);
            checkOutput("result_lo", lo, mon_e.e_lo);
         end
      end
      prev_done <= done;
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running, required finish");
      $fatal(1);
   end

   // Directed test sequence.
   initial begin
      rst   = 1'b1;
      start = 1'b0;
      flush = 1'b0;
      wr_hi = 1'b0;
      wr_lo = 1'b0;
      op    = 2'b00;
      A     = '0;
      B     = '0;
      wdata = '0;

      vecs = '{
         '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
         '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB},
         '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
         '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
         '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
         '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
         '{2'b10, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF},
         '{2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF}
      };

      repeat (2) @(negedge clk);
      checkOutput("reset_busy", {31'b0, busy}, 32'd0);
      checkOutput("reset_done", {31'b0, done}, 32'd0);
      checkOutput("reset_hi", hi, 32'd0);
      checkOutput("reset_lo", lo, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Table of arithmetic cases, issued back to back in the done cycle.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].v_op, vecs[i].v_a, vecs[i].v_b, 1'b1, vecs[i].v_hi, vecs[i].v_lo);
         waitDone();
      end
      @(negedge clk);

      // start, wr_lo while busy are ignored; MTHI in idle afterwards.
      $display("[TB] busy-ignore sequence");
      applyStimulus(2'b00, 32'd6, 32'd7, 1'b1, 32'h0, 32'h2A);
      repeat (4) @(negedge clk);
      op    = 2'b10;
      A     = 32'd99;
      B     = 32'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      wr_lo = 1'b1;
      wdata = 32'h1234;
      @(negedge clk);
      wr_lo = 1'b0;
      waitDone();
      wr_hi = 1'b1;
      wdata = 32'hABCD;
      @(negedge clk);
      wr_hi = 1'b0;
      checkOutput("mthi_hi", hi, 32'hABCD);
      checkOutput("mthi_lo", lo, 32'h2A);

      // MTHI+MTLO together with start: writes land, then the result overwrites.
      wr_hi = 1'b1;
      wr_lo = 1'b1;
      wdata = 32'h55;
      applyStimulus(2'b00, 32'd2, 32'd3, 1'b1, 32'h0, 32'h6);
      wr_hi = 1'b0;
      wr_lo = 1'b0;
      checkOutput("wr_with_start_hi", hi, 32'h55);
      checkOutput("wr_with_start_lo", lo, 32'h55);
      waitDone();
      @(negedge clk);

      // Flush mid-operation, then a flushed start in idle.
      $display("[TB] flush sequence");
      wr_hi = 1'b1;
      wdata = 32'h11;
      @(negedge clk);
      wr_hi = 1'b0;
      wr_lo = 1'b1;
      wdata = 32'h22;
      @(negedge clk);
      wr_lo = 1'b0;
      applyStimulus(2'b00, 32'd3, 32'd4, 1'b0, 32'h0, 32'h0);
      repeat (11) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checkOutput("flush_busy", {31'b0, busy}, 32'd0);
      start = 1'b1;
      flush = 1'b1;
      op    = 2'b00;
      A     = 32'd1;
      B     = 32'd1;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      checkOutput("idle_flush_busy", {31'b0, busy}, 32'd0);
      repeat (40) @(negedge clk);
      checkOutput("flush_hi", hi, 32'h11);
      checkOutput("flush_lo", lo, 32'h22);

      // Asynchronous reset mid-operation, then a clean DIVU.
      $display("[TB] reset sequence");
      applyStimulus(2'b00, 32'd9, 32'd9, 1'b0, 32'h0, 32'h0);
      repeat (20) @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("midreset_busy", {31'b0, busy}, 32'd0);
      checkOutput("midreset_done", {31'b0, done}, 32'd0);
      checkOutput("midreset_hi", hi, 32'd0);
      checkOutput("midreset_lo", lo, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      applyStimulus(2'b10, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
      waitDone();

      repeat (3) @(negedge clk);
      checkOutput("queue_drain", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
